mcu_packet_parser: RTL
======================

// Module: mcu_packet_parser
// PURPOSE
//  Sits between the MCU-side SPI byte receiver and pit_hash_table/PIT. Parses framed MCU bytes
//  into metadata, a left-aligned 64-bit prefix and a prefix length for the PIT hash lookup.
//  Buffers data-packet payload bytes in an internal FIFO so the SPI side never stalls.
//  Frame format: META, PLEN, N prefix bytes (MSB first); data packets also carry PAYLEN and then PAYLEN payload bytes.
// PARAMETERS
//  FIFO_DEPTH   16    payload FIFO entries (power of 2, >=2)
//  TIMEOUT      1024  max clk cycles between bytes inside a frame before abort
// PORTS
//  clk             in   1   system clock, all logic rising-edge
//  rst             in   1   asynchronous, active-low reset
//  cs_active       in   1   MCU chip select asserted (frame envelope), synchronised upstream
//  rx_valid        in   1   1-cycle strobe: rx_byte holds a new received byte
//  rx_byte         in   8   received byte
//  prefix_out      out  64  prefix, byte0 in [63:56], unused low bytes zero
//  length_out      out  6   prefix length in bits minus 1 (N*8-1)
//  metadata_out    out  8   META byte as received
//  interest_packet out  1   META[7]: 1=interest, 0=data
//  prefix_valid    out  1   prefix/length/metadata/interest valid, held until prefix_ack
//  prefix_ack      in   1   consumer accepts prefix (valid&&ack = transfer)
//  data_out        out  8   payload FIFO head
//  data_valid      out  1   FIFO not empty
//  data_ready      in   1   consumer pops head (valid&&ready = pop)
//  frame_error     out  1   1-cycle pulse on any frame abort
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied; state IDLE. Reset mid-frame discards everything.
//  FSM: IDLE, META, PLEN, PREFIX, PAYLEN, PAYLOAD, DRAIN.
//   IDLE->META when cs_active=1. META: rx byte -> meta_reg, ->PLEN.
//   PLEN: N=rx_byte[3:0]; N==0, N>8 or rx_byte[7:4]!=0 -> abort; else byte_cnt=0, ->PREFIX.
//   PREFIX: byte k written to prefix[63-8k -: 8]; after byte N: publish, then
//    interest -> DRAIN; data -> PAYLEN.
//   PAYLEN: L=rx_byte; L==0 -> DRAIN; else ->PAYLOAD. PAYLOAD: each byte pushed; after L-th ->DRAIN.
//   DRAIN: wait cs_active=0 -> IDLE. Any rx_valid in DRAIN -> abort (extra bytes).
//  Publish: prefix_out/length_out/metadata_out/interest_packet/prefix_valid update on the clk edge
//   after the rx_valid cycle of the last prefix byte (1-cycle latency). Unused prefix bytes zero.
//   Outputs stable while prefix_valid=1; prefix_valid clears the edge after valid&&ack.
//   If publish needed while prefix_valid still 1 (not acked in same cycle) -> abort, old prefix kept.
//   Publish and ack in the same cycle: new prefix loaded, prefix_valid stays 1.
//  Prefix handshake independent of FSM: an already-published prefix survives later aborts.
//  Abort causes: bad PLEN, cs_active=0 in META..PAYLOAD, inter-byte timeout (counter reset on each
//   rx_valid, abort when it reaches TIMEOUT in META..PAYLOAD), FIFO overflow, prefix overrun,
//   extra byte in DRAIN. Abort: frame_error=1 for one cycle, ->DRAIN, partial prefix never
//   published, payload bytes already in FIFO kept (no flush).
//  FIFO: circular, ptrs wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH. Push in PAYLOAD on rx_valid.
//   data_valid rises the edge after first push (1-cycle latency); data_out is head, combinational from RAM.
//   Push when full: byte dropped, abort; except push&&pop same cycle when full -> both succeed.
//   Pop when empty ignored. Push&&pop same cycle: count unchanged.
//  rx_valid in IDLE ignored. cs_active=0 in DRAIN/IDLE is the normal end of frame.
// TESTING
//  Interest 80,02,AB,CD, ack held 0 -> prefix_out=ABCD000000000000, length_out=15, interest=1,
//   prefix_valid 1 cycle after 0xCD, held until ack pulse, then 0.
//  Data 05,01,11,03,AA,BB,CC, data_ready=1 -> prefix_out=1100..00, length_out=7, interest=0,
//   data_out AA,BB,CC popped in order, data_valid 0 afterwards, frame_error never 1.
//  PLEN=09 -> frame_error pulse, no prefix_valid, busy until cs_active=0.
//  Data PAYLEN=17, data_ready=0 -> 16 bytes buffered, 17th aborts (frame_error), FIFO holds 16.
//  cs_active drop after 2 of 4 prefix bytes -> frame_error, no publish; rst=0 mid-payload -> all outputs 0.
//  Second frame completes with prefix_valid still 1 -> frame_error, first prefix unchanged.

Source files
------------

// File: rtl/mcu_packet_parser.sv
// mcu_packet_parser: parses framed MCU SPI bytes into a PIT lookup prefix and buffers
// data-packet payload in a small FIFO.
module mcu_packet_parser #(
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_active,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic [63:0] prefix_out,
   output logic [5:0]  length_out,
   output logic [7:0]  metadata_out,
   output logic        interest_packet,
   output logic        prefix_valid,
   input  logic        prefix_ack,
   output logic [7:0]  data_out,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        frame_error,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_META, S_PLEN, S_PREFIX, S_PAYLEN, S_PAYLOAD, S_DRAIN} state_t;

   state_t        r_state, w_next;
   logic [7:0]    r_meta, r_len;
   logic [3:0]    r_n, r_cnt;
   logic [63:0]   r_acc, w_acc;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_count;
   logic          w_active, w_tmo, w_full, w_pop, w_push, w_pub, w_abort;

   assign w_active   = (r_state != S_IDLE) && (r_state != S_DRAIN);
   assign w_tmo      = r_tmo == TW'(TIMEOUT);
   assign w_full     = r_count == (AW+1)'(FIFO_DEPTH);
   assign w_pop      = (r_count != '0) && data_ready;
   assign w_acc      = r_acc | ({rx_byte, 56'b0} >> {r_cnt[2:0], 3'b000});
   assign data_valid = r_count != '0;
   assign data_out   = data_valid ? r_mem[r_rp] : '0;
   assign busy       = r_state != S_IDLE;

   always_comb begin
      w_next  = r_state;
      w_abort = 1'b0;
      w_pub   = 1'b0;
      w_push  = 1'b0;
      case (r_state)
         S_IDLE:    if (cs_active) w_next = S_META;
         S_META:    if (rx_valid) w_next = S_PLEN;
         S_PLEN:
            if (rx_valid) begin
               if (rx_byte[7:4] != 4'd0 || rx_byte[3:0] == 4'd0 || rx_byte[3:0] > 4'd8) w_abort = 1'b1;
               else w_next = S_PREFIX;
            end
         S_PREFIX:
            if (rx_valid && r_cnt == r_n - 4'd1) begin
               if (prefix_valid && !prefix_ack) w_abort = 1'b1;
               else begin
                  w_pub  = 1'b1;
                  w_next = r_meta[7] ? S_DRAIN : S_PAYLEN;
               end
            end
         S_PAYLEN:  if (rx_valid) w_next = (rx_byte == 8'd0) ? S_DRAIN : S_PAYLOAD;
         S_PAYLOAD:
            if (rx_valid) begin
               // a full FIFO can still accept when its head leaves in the same cycle
               if (w_full && !w_pop) w_abort = 1'b1;
               else begin
                  w_push = 1'b1;
                  if (r_len == 8'd1) w_next = S_DRAIN;
               end
            end
         S_DRAIN:
            if (!cs_active) w_next = S_IDLE;
            else if (rx_valid) w_abort = 1'b1;
         default:   w_next = S_IDLE;
      endcase
      if (w_active && (!cs_active || w_tmo)) begin
         w_abort = 1'b1;
         w_pub   = 1'b0;
         w_push  = 1'b0;
      end
      if (w_abort) w_next = S_DRAIN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= S_IDLE;
         r_meta          <= '0;
         r_len           <= '0;
         r_n             <= '0;
         r_cnt           <= '0;
         r_acc           <= '0;
         r_tmo           <= '0;
         r_wp            <= '0;
         r_rp            <= '0;
         r_count         <= '0;
         prefix_out      <= '0;
         length_out      <= '0;
         metadata_out    <= '0;
         interest_packet <= 1'b0;
         prefix_valid    <= 1'b0;
         frame_error     <= 1'b0;
      end else begin
         r_state     <= w_next;
         frame_error <= w_abort;
         r_tmo       <= (rx_valid || !w_active) ? '0 : w_tmo ? r_tmo : r_tmo + 1'b1;
         if (r_state == S_META && rx_valid) r_meta <= rx_byte;
         if (r_state == S_PLEN && rx_valid) begin
            r_n   <= rx_byte[3:0];
            r_cnt <= '0;
            r_acc <= '0;
         end
         if (r_state == S_PREFIX && rx_valid) begin
            r_acc <= w_acc;
            r_cnt <= r_cnt + 4'd1;
         end
         if (r_state == S_PAYLEN && rx_valid) r_len <= rx_byte;
         if (w_push) r_len <= r_len - 8'd1;
         if (w_pub) begin
            prefix_out      <= w_acc;
            length_out      <= 6'({r_n, 3'b000} - 7'd1);
            metadata_out    <= r_meta;
            interest_packet <= r_meta[7];
         end
         prefix_valid <= w_pub || (prefix_valid && !prefix_ack);
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= rx_byte;
   end
endmodule
